// File: rtl/toy_phy_regfile_entry_ckpt.sv
// Per-physical-register rename state: allocation, writeback readiness, commit
// ownership and per-checkpoint liveness snapshots for selective mispredict recovery.
module toy_phy_regfile_entry_ckpt #(
    parameter int PHY_REG_ID     = 95,
    parameter int MODE           = 0,
    parameter int PHY_REG_NUM    = 128,
    parameter int ARCH_ENTRY_NUM = 32,
    parameter int REG_WIDTH      = 64,
    parameter int WR_NUM         = 10,
    parameter int ALLOC_NUM      = 4,
    parameter int REL_NUM        = 4,
    parameter int CKPT_NUM       = 8,
    localparam int PHY_W         = $clog2(PHY_REG_NUM),
    localparam int CK_W          = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ALLOC_NUM-1:0]              v_alloc_en,
    input  logic [ALLOC_NUM-1:0]              v_alloc_zero,
    input  logic [ALLOC_NUM-1:0][PHY_W-1:0]   v_alloc_id,
    input  logic [WR_NUM-1:0]                 v_wr_en,
    input  logic [WR_NUM-1:0][PHY_W-1:0]      v_wr_index,
    input  logic [WR_NUM-1:0][REG_WIDTH-1:0]  v_wr_data,
    input  logic [REL_NUM-1:0]                v_rel_en,
    input  logic [REL_NUM-1:0][PHY_W-1:0]     v_rel_index,
    input  logic [REL_NUM-1:0]                v_cmt_en,
    input  logic [REL_NUM-1:0][PHY_W-1:0]     v_cmt_index,
    input  logic                              ckpt_save_en,
    input  logic [CK_W-1:0]                   ckpt_save_id,
    input  logic                              ckpt_restore_en,
    input  logic [CK_W-1:0]                   ckpt_restore_id,
    input  logic                              flush_en,
    output logic                              entry_idle,
    output logic                              reg_phy_rdy,
    output logic [REG_WIDTH-1:0]              reg_phy_data,
    output logic                              err_flag
);

    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    localparam bit             IS_ZERO = (MODE == 0) && (PHY_REG_ID == 0);
    localparam bit             IS_ARCH = (PHY_REG_ID < ARCH_ENTRY_NUM);
    localparam logic [PHY_W-1:0] MY_ID = PHY_W'(PHY_REG_ID);

    logic [ALLOC_NUM-1:0] alloc_vec;
    logic [WR_NUM-1:0]    wr_vec;
    logic [REL_NUM-1:0]   rel_vec;
    logic [REL_NUM-1:0]   cmt_vec;

    for (genvar i = 0; i < ALLOC_NUM; i++) begin : g_alloc
        // In INT mode an x0 destination never claims a physical register.
        assign alloc_vec[i] = v_alloc_en[i] && (v_alloc_id[i] == MY_ID) &&
                              ((MODE != 0) || !v_alloc_zero[i]);
    end
    for (genvar i = 0; i < WR_NUM; i++) begin : g_wr
        assign wr_vec[i] = v_wr_en[i] && (v_wr_index[i] == MY_ID);
    end
    for (genvar i = 0; i < REL_NUM; i++) begin : g_rel
        assign rel_vec[i] = v_rel_en[i] && (v_rel_index[i] == MY_ID);
        assign cmt_vec[i] = v_cmt_en[i] && (v_cmt_index[i] == MY_ID);
    end

    logic alloc_hit, wr_hit, rel_hit, cmt_hit;
    logic alloc_multi, wr_multi;
    assign alloc_hit   = |alloc_vec;
    assign wr_hit      = |wr_vec;
    assign rel_hit     = |rel_vec;
    assign cmt_hit     = |cmt_vec;
    assign alloc_multi = |(alloc_vec & (alloc_vec - ALLOC_NUM'(1)));
    assign wr_multi    = |(wr_vec & (wr_vec - WR_NUM'(1)));

    logic [1:0]           state, state_nxt;
    logic                 committed;
    logic [CKPT_NUM-1:0]  snap;
    logic [REG_WIDTH-1:0] data;
    logic                 err;

    logic [REG_WIDTH-1:0] wr_data_sel;
    always_comb begin
        wr_data_sel = '0;
        // Walk downward so the lowest matching port is the last assignment.
        for (int i = WR_NUM - 1; i >= 0; i--) begin
            if (wr_vec[i]) wr_data_sel = v_wr_data[i];
        end
    end

    logic snap_sel, kill_ok, err_nxt;
    assign snap_sel = snap[ckpt_restore_id];
    // A committed mapping (or one committing now) survives flush and restore.
    assign kill_ok  = !committed && !cmt_hit;

    always_comb begin
        state_nxt = state;
        if (rel_hit)                                  state_nxt = ST_FREE;
        else if (flush_en && kill_ok)                 state_nxt = ST_FREE;
        else if (ckpt_restore_en && !snap_sel && kill_ok) state_nxt = ST_FREE;
        else if (wr_hit && state == ST_PEND)          state_nxt = ST_VALID;
        else if (alloc_hit && state == ST_FREE)       state_nxt = ST_PEND;
    end

    assign err_nxt = (alloc_hit && state != ST_FREE) || alloc_multi || wr_multi ||
                     (rel_hit && state == ST_FREE) || (rel_hit && cmt_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IS_ARCH ? ST_VALID : ST_FREE;
            committed <= IS_ARCH;
            snap      <= '0;
            data      <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err | err_nxt;
            if (wr_hit) data <= wr_data_sel;
            if (rel_hit) begin
                committed <= 1'b0;
                snap      <= '0;
            end else begin
                if (cmt_hit) committed <= 1'b1;
                // Allocations landing in the save cycle count as live in the snapshot.
                if (ckpt_save_en && !ckpt_restore_en)
                    snap[ckpt_save_id] <= (state != ST_FREE) || alloc_hit;
            end
        end
    end

    assign reg_phy_rdy  = IS_ZERO ? 1'b1 : (state != ST_PEND);
    assign entry_idle   = IS_ZERO ? 1'b0 : ((state == ST_FREE) && !alloc_hit);
    assign reg_phy_data = IS_ZERO ? '0   : data;
    assign err_flag     = IS_ZERO ? 1'b0 : err;

endmodule

// File: doc/toy_phy_regfile_entry_ckpt.md
# toy_phy_regfile_entry_ckpt

Per-entry state holder for one physical register in the rename/dispatch stage. It is the parametrised successor of the single-backup entry. It tracks allocation, writeback readiness, commit ownership and N branch-checkpoint snapshots, so mispredicts restore selectively instead of only by full flush. One instance exists per physical register; the free-list scan reads `entry_idle` and the issue queues read `reg_phy_rdy`.

## Interface
- PHY_REG_ID, 95, physical register index of this instance
- MODE, 0, 0 = INT (ID 0 hardwired zero, alloc_zero honoured), 1 = FP
- PHY_REG_NUM, 128, total physical registers; PHY_W = $clog2(PHY_REG_NUM)
- ARCH_ENTRY_NUM, 32, IDs below this reset as committed architectural mappings
- REG_WIDTH, 64, data width
- WR_NUM, 10, writeback ports
- ALLOC_NUM, 4, rename allocation channels
- REL_NUM, 4, commit channels
- CKPT_NUM, 8, checkpoints; CK_W = max(1,$clog2(CKPT_NUM))
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- v_alloc_en / v_alloc_zero  in  ALLOC_NUM each  allocation valid / destination is x0
- v_alloc_id  in  PHY_W×ALLOC_NUM  allocated IDs
- v_wr_en  in  WR_NUM  writeback valid
- v_wr_index  in  PHY_W×WR_NUM  writeback IDs
- v_wr_data  in  REG_WIDTH×WR_NUM  writeback data
- v_rel_en  in  REL_NUM  commit releases old mapping
- v_rel_index  in  PHY_W×REL_NUM  released IDs
- v_cmt_en  in  REL_NUM  commit makes new mapping architectural
- v_cmt_index  in  PHY_W×REL_NUM  newly committed IDs
- ckpt_save_en  in  1  snapshot taken this cycle
- ckpt_save_id  in  CK_W  slot to write
- ckpt_restore_en  in  1  mispredict restore
- ckpt_restore_id  in  CK_W  slot to restore
- flush_en  in  1  full cancel back to committed state
- entry_idle  out  1  FREE and not being allocated this cycle (combinational)
- reg_phy_rdy  out  1  data valid for consumers
- reg_phy_data  out  REG_WIDTH  register contents
- err_flag  out  1  sticky protocol error

## Operation
- Hits: alloc_hit = any v_alloc_en[i] with matching ID (and ~v_alloc_zero[i] when MODE=0). wr_hit, rel_hit and cmt_hit are defined the same way over their own channels.
- State: FREE, PEND (allocated, awaiting writeback), VALID. Also kept: `committed` bit and `snap[CKPT_NUM]`.
- Outputs: reg_phy_rdy = (state != PEND). entry_idle = (state == FREE) & ~alloc_hit.
- Next-state priority, highest first:
  1. rel_hit: FREE; committed←0; snap←0.
  2. flush_en & ~committed & ~cmt_hit: FREE.
  3. ckpt_restore_en & ~snap[restore_id] & ~committed & ~cmt_hit: FREE.
  4. wr_hit & state==PEND: VALID.
  5. alloc_hit & state==FREE: PEND.
- cmt_hit sets committed←1 unless rel_hit is also active. rel_hit wins and sets err_flag.
- Write data: on wr_hit, data←v_wr_data of the lowest-index matching port. This happens in any state, including alongside rows 1–3. More than one port matching sets err_flag.
- Checkpoint save: snap[save_id] ← (state != FREE) | alloc_hit. Allocations in the save cycle belong to the snapshot. If ckpt_restore_en is active in the same cycle, the save is ignored.
- Errors (err_flag sticky until reset):
  - alloc_hit while state != FREE
  - more than one alloc channel hitting
  - multiple write-port hits
  - rel_hit with state==FREE
- MODE=0, PHY_REG_ID=0: constant. data=0, rdy=1, idle=0, err_flag=0, all inputs ignored.

## Timing
- Reset values:
  - PHY_REG_ID < ARCH_ENTRY_NUM: VALID, committed=1.
  - Otherwise: FREE, committed=0.
  - All IDs: snap=0, data=0, err_flag=0.
  - Outputs right after reset: rdy=1; idle=1 only for non-architectural IDs.
- Alloc in cycle T: entry_idle drops in T (comb bypass); rdy=0 from T+1.
- Writeback in T: data and rdy=1 visible at T+1. Alloc and wr_hit in the same cycle on a FREE entry: PEND at T+1, data updated. Writeback completion needs a later write.
- Release/flush/restore in T: FREE at T+1; entry_idle=1 from T+1 unless re-allocated in T+1.
- Reset deasserting mid-operation discards all state; no pending transition survives.

## Test plan
- Reset, ID=40: idle=1, rdy=1, data=0. Alloc on ch2 in cycle 1: idle=0 in cycle 1, rdy=0 in cycle 2. Write 0xDEAD via port 7 in cycle 3: rdy=1 and data=0xDEAD in cycle 4.
- Ports 3 and 5 write the same ID together with 0x11 and 0x22: data=0x11, err_flag=1.
- ID=40:
  - Save slot 1 while FREE; alloc in the next cycle; restore slot 1: entry returns to FREE, idle=1.
  - Repeat, but save in the same cycle as the alloc: after restore, entry stays PEND.
- ID=40 allocated, cmt_hit, then flush_en: stays non-FREE, committed=1. A later rel_hit: FREE, snap cleared, no error.
- MODE=0, ID=0: alloc, write 0x5 and flush: data=0, rdy=1, idle=0 throughout. Alloc with v_alloc_zero=1 on ID 40: no state change.
- Alloc ID 40 while PEND: err_flag=1 and stays set. Async reset asserted mid-PEND: immediate FREE, err_flag=0.
